// File: rtl/rail_pwr_seq_if.sv
// rail_pwr_seq_if: request, power-good and status bundle between firmware/board and the rail sequencer.
interface rail_pwr_seq_if #(
    parameter int NUM_RAILS = 4
);
    localparam int IDX_W = $clog2(NUM_RAILS);
    logic                 pwr_on_req;
    logic [NUM_RAILS-1:0] pg_in;
    logic                 clr_fault;
    logic [NUM_RAILS-1:0] rail_en;
    logic                 pwr_ready;
    logic                 fault;
    logic [IDX_W-1:0]     fault_rail;
    modport master (
        output pwr_on_req, pg_in, clr_fault,
        input  rail_en, pwr_ready, fault, fault_rail
    );
    modport slave (
        input  pwr_on_req, pg_in, clr_fault,
        output rail_en, pwr_ready, fault, fault_rail
    );
endinterface

// File: rtl/rail_pwr_seq.sv
// rail_pwr_seq: sequences rail enables up in ascending and down in descending order, dropping all rails on a power-good fault.
module rail_pwr_seq #(
    parameter int NUM_RAILS  = 4,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 100,
    parameter int PG_TIMEOUT = 1000
) (
    input logic           clk,
    input logic           rst_n,
    rail_pwr_seq_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_RAILS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_RAILS - 1);
    typedef enum logic [2:0] {IDLE, UP_PG, UP_SETTLE, ON, DOWN, FAULT} state_t;
    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_RAILS-1:0] r_rail_en;
    logic                 r_pwr_ready;
    logic                 r_fault;
    logic [IDX_W-1:0]     r_fault_rail;
    logic [NUM_RAILS-1:0] w_idx_oh;
    logic                 w_pg_cur;
    logic                 w_timeout;
    logic                 w_settled;
    logic                 w_monitor;
    logic [NUM_RAILS-1:0] w_bad;
    logic                 w_flt;
    logic [IDX_W-1:0]     w_low;
    assign w_idx_oh  = NUM_RAILS'(1) << r_idx;
    assign w_pg_cur  = |(bus.pg_in & w_idx_oh);
    assign w_settled = r_cnt == CNT_W'(SETTLE_CYC - 1);
    assign w_timeout = r_state == UP_PG && !w_pg_cur && r_cnt == CNT_W'(PG_TIMEOUT - 1);
    assign w_monitor = r_state == UP_PG || r_state == UP_SETTLE || r_state == ON;
    // The rail still ramping in UP_PG is judged only by its timeout, folded in so the lower index wins.
    assign w_bad = w_monitor ? ((r_rail_en & ~(r_state == UP_PG ? w_idx_oh : '0) & ~bus.pg_in)
                                | (w_timeout ? w_idx_oh : '0)) : '0;
    assign w_flt = |w_bad;
    always_comb begin
        w_low = '0;
        for (int j = NUM_RAILS - 1; j >= 0; j--) w_low = w_bad[j] ? IDX_W'(j) : w_low;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_rail_en    <= '0;
            r_pwr_ready  <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_rail <= '0;
        end else if (w_flt) begin
            r_state      <= FAULT;
            r_cnt        <= '0;
            r_rail_en    <= '0;
            r_pwr_ready  <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_rail <= w_low;
        end else begin
            case (r_state)
                IDLE: if (bus.pwr_on_req) begin
                    r_state   <= UP_PG;
                    r_idx     <= '0;
                    r_cnt     <= '0;
                    r_rail_en <= NUM_RAILS'(1);
                end
                UP_PG, UP_SETTLE: if (!bus.pwr_on_req) begin
                    r_state   <= DOWN;
                    r_cnt     <= '0;
                    r_rail_en <= r_rail_en & ~w_idx_oh;
                end else if (r_state == UP_PG) begin
                    r_state <= w_pg_cur ? UP_SETTLE : UP_PG;
                    r_cnt   <= w_pg_cur ? '0 : r_cnt + CNT_W'(1);
                end else if (!w_settled) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (r_idx == LAST) begin
                    r_state     <= ON;
                    r_cnt       <= '0;
                    r_pwr_ready <= 1'b1;
                end else begin
                    r_state   <= UP_PG;
                    r_idx     <= r_idx + IDX_W'(1);
                    r_cnt     <= '0;
                    r_rail_en <= r_rail_en | (w_idx_oh << 1);
                end
                ON: if (!bus.pwr_on_req) begin
                    r_state     <= DOWN;
                    r_idx       <= LAST;
                    r_cnt       <= '0;
                    r_rail_en   <= r_rail_en & ~(NUM_RAILS'(1) << LAST);
                    r_pwr_ready <= 1'b0;
                end
                DOWN: if (!w_settled) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (r_idx == '0) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_idx     <= r_idx - IDX_W'(1);
                    r_cnt     <= '0;
                    r_rail_en <= r_rail_en & ~(w_idx_oh >> 1);
                end
                FAULT: if (bus.clr_fault && !bus.pwr_on_req) begin
                    r_state      <= IDLE;
                    r_idx        <= '0;
                    r_fault      <= 1'b0;
                    r_fault_rail <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.rail_en    = r_rail_en;
    assign bus.pwr_ready  = r_pwr_ready;
    assign bus.fault      = r_fault;
    assign bus.fault_rail = r_fault_rail;
endmodule

// File: tb/tb_rail_pwr_seq.sv
// tb_rail_pwr_seq: directed checks of rail_pwr_seq with 3 rails, settle 4, timeout 8.
module tb_rail_pwr_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] r_pg = '0;
    logic [2:0] pg_low = '0;
    int         p = 0;
    int         n_run = 0;
    int         n_fail = 0;
    rail_pwr_seq_if #(.NUM_RAILS(3)) bus ();
    rail_pwr_seq #(.NUM_RAILS(3), .CNT_W(16), .SETTLE_CYC(4), .PG_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    // Board model: each rail reports power-good one clock after its enable is seen.
    always @(posedge clk) r_pg <= bus.rail_en;
    assign bus.pg_in = r_pg & ~pg_low;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, p);
        end
    endtask
    task automatic step_to(input int target);
        repeat (target - p) @(posedge clk);
        p = target;
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        bus.pwr_on_req = 1'b0;
        bus.clr_fault = 1'b0;
        pg_low = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p = 0;
    endtask
    task automatic power_up_to_on();
        bus.pwr_on_req = 1'b1;
        step_to(19);
        check("on_ready", 32'(bus.pwr_ready), 1);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        do_reset();
        check("rst_rail_en", 32'(bus.rail_en), 0);
        check("rst_ready", 32'(bus.pwr_ready), 0);
        check("rst_fault", 32'(bus.fault), 0);
        check("rst_fault_rail", 32'(bus.fault_rail), 0);
        bus.pwr_on_req = 1'b1;
        step_to(1);  check("up_e1", 32'(bus.rail_en), 3'b001);
        step_to(6);  check("up_e6", 32'(bus.rail_en), 3'b001);
        step_to(7);  check("up_e7", 32'(bus.rail_en), 3'b011);
        step_to(12); check("up_e12", 32'(bus.rail_en), 3'b011);
        step_to(13); check("up_e13", 32'(bus.rail_en), 3'b111);
        step_to(18); check("ready_e18", 32'(bus.pwr_ready), 0);
        step_to(19); check("ready_e19", 32'(bus.pwr_ready), 1);
        check("up_fault", 32'(bus.fault), 0);
        step_to(30); bus.pwr_on_req = 1'b0;
        step_to(31); check("dn_e31", 32'(bus.rail_en), 3'b011);
        check("dn_ready_e31", 32'(bus.pwr_ready), 0);
        step_to(34); check("dn_e34", 32'(bus.rail_en), 3'b011);
        step_to(35); check("dn_e35", 32'(bus.rail_en), 3'b001);
        step_to(39); check("dn_e39", 32'(bus.rail_en), 3'b000);
        step_to(40); bus.pwr_on_req = 1'b1;
        step_to(43); check("dn_idle_e43", 32'(bus.rail_en), 3'b000);
        step_to(44); check("restart_e44", 32'(bus.rail_en), 3'b001);
        do_reset();
        pg_low = 3'b010;
        bus.pwr_on_req = 1'b1;
        step_to(7);  check("to_e7", 32'(bus.rail_en), 3'b011);
        step_to(14); check("to_e14_fault", 32'(bus.fault), 0);
        step_to(15); check("to_fault", 32'(bus.fault), 1);
        check("to_fault_rail", 32'(bus.fault_rail), 1);
        check("to_rail_en", 32'(bus.rail_en), 0);
        check("to_ready", 32'(bus.pwr_ready), 0);
        bus.clr_fault = 1'b1;
        step_to(16); bus.clr_fault = 1'b0;
        check("clr_with_req", 32'(bus.fault), 1);
        bus.pwr_on_req = 1'b0;
        step_to(17); check("fault_hold", 32'(bus.fault), 1);
        bus.clr_fault = 1'b1;
        step_to(18); bus.clr_fault = 1'b0;
        check("clr_fault", 32'(bus.fault), 0);
        check("clr_fault_rail", 32'(bus.fault_rail), 0);
        bus.pwr_on_req = 1'b1;
        step_to(19); check("clr_idle_restart", 32'(bus.rail_en), 3'b001);
        do_reset();
        power_up_to_on();
        step_to(20); pg_low = 3'b101;
        step_to(21); pg_low = 3'b000;
        check("loss_fault", 32'(bus.fault), 1);
        check("loss_fault_rail", 32'(bus.fault_rail), 0);
        check("loss_rail_en", 32'(bus.rail_en), 0);
        check("loss_ready", 32'(bus.pwr_ready), 0);
        do_reset();
        bus.pwr_on_req = 1'b1;
        step_to(10); bus.pwr_on_req = 1'b0;
        step_to(11); check("ab_e11", 32'(bus.rail_en), 3'b001);
        step_to(14); check("ab_e14", 32'(bus.rail_en), 3'b001);
        step_to(15); check("ab_e15", 32'(bus.rail_en), 3'b000);
        step_to(16); bus.pwr_on_req = 1'b1;
        step_to(19); check("ab_ignored_e19", 32'(bus.rail_en), 3'b000);
        step_to(20); check("ab_restart_e20", 32'(bus.rail_en), 3'b001);
        step_to(26); check("ab_restart_e26", 32'(bus.rail_en), 3'b011);
        check("ab_fault", 32'(bus.fault), 0);
        do_reset();
        bus.pwr_on_req = 1'b1;
        step_to(13); check("ar_e13", 32'(bus.rail_en), 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("ar_rail_en", 32'(bus.rail_en), 0);
        check("ar_ready", 32'(bus.pwr_ready), 0);
        check("ar_fault", 32'(bus.fault), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p = 0;
        check("ar_released", 32'(bus.rail_en), 0);
        step_to(1); check("ar_idle_restart", 32'(bus.rail_en), 3'b001);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
